// File: rtl/battleship_pkg.sv
// battleship_pkg: shared cell and phase types for the Battleship board controller
package battleship_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_SHIP  = 2'd1,
        CELL_MISS  = 2'd2,
        CELL_HIT   = 2'd3
    } cell_t;

    typedef enum logic [1:0] {
        S_AMOUNT = 2'd0,
        S_PLACE  = 2'd1,
        S_FIRE   = 2'd2,
        S_OVER   = 2'd3
    } state_t;

endpackage

// File: rtl/battleship_btn_edge.sv
// battleship_btn_edge: single-cycle pulse on the rising edge of a synchronised button level
module battleship_btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic prev;

    // remember the last level so a held button yields only one pulse
    always_ff @(posedge clk) prev <= !rst ? 1'b0 : btn;

    assign rise = btn & ~prev;

endmodule

// File: rtl/battleship_board_ctrl.sv
// battleship_board_ctrl: ROWS x COLS Battleship board with placement and firing phases (CURSOR_WRAP_EN: wrap cursor at edges)
module battleship_board_ctrl
    import battleship_pkg::*;
#(
    parameter int ROWS      = 5,
    parameter int COLS      = 5,
    parameter int MAX_SHIPS = 5,
    parameter int CNT_W     = $clog2(MAX_SHIPS + 1),
    localparam int RW       = $clog2(ROWS),
    localparam int CW       = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             move_up,
    input  logic             move_down,
    input  logic             move_left,
    input  logic             move_right,
    input  logic [CNT_W-1:0] player_ships_input,
    input  logic             confirm_amount_button,
    input  logic             confirm_colocation_button,
    input  logic             fire_button,
    input  logic [RW-1:0]    rd_row,
    input  logic [CW-1:0]    rd_col,
    output logic [1:0]       rd_cell,
    output logic [RW-1:0]    cursor_row,
    output logic [CW-1:0]    cursor_col,
    output logic [CNT_W-1:0] ships_placed,
    output logic [CNT_W-1:0] hits,
    output logic [1:0]       phase,
    output logic             placement_error,
    output logic             game_over
);

    localparam logic [RW-1:0]    ROW_MAX  = RW'(ROWS - 1);
    localparam logic [CW-1:0]    COL_MAX  = CW'(COLS - 1);
    localparam logic [CNT_W-1:0] SHIP_MAX = CNT_W'(MAX_SHIPS);

    state_t           state, state_n;
    cell_t            board [ROWS][COLS];
    cell_t            cur, wr_val;
    logic             wr_en, err_n, cur_moves;
    logic [RW-1:0]    row_n, row_dec, row_inc;
    logic [CW-1:0]    col_n, col_dec, col_inc;
    logic [CNT_W-1:0] target, target_n, placed_n, hits_n;
    logic [6:0]       btn_lvl, btn_rise;
    logic             up_e, down_e, left_e, right_e, amt_e, place_e, fire_e;

    assign btn_lvl = {move_up, move_down, move_left, move_right,
                      confirm_amount_button, confirm_colocation_button, fire_button};

    for (genvar b = 0; b < 7; b++) begin : g_btn
        battleship_btn_edge u_edge (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn_lvl[b]),
            .rise (btn_rise[b])
        );
    end

    assign {up_e, down_e, left_e, right_e, amt_e, place_e, fire_e} = btn_rise;

`ifdef CURSOR_WRAP_EN
    assign row_dec = (cursor_row == '0)      ? ROW_MAX : cursor_row - RW'(1);
    assign row_inc = (cursor_row == ROW_MAX) ? '0      : cursor_row + RW'(1);
    assign col_dec = (cursor_col == '0)      ? COL_MAX : cursor_col - CW'(1);
    assign col_inc = (cursor_col == COL_MAX) ? '0      : cursor_col + CW'(1);
`else
    assign row_dec = (cursor_row == '0)      ? '0      : cursor_row - RW'(1);
    assign row_inc = (cursor_row == ROW_MAX) ? ROW_MAX : cursor_row + RW'(1);
    assign col_dec = (cursor_col == '0)      ? '0      : cursor_col - CW'(1);
    assign col_inc = (cursor_col == COL_MAX) ? COL_MAX : cursor_col + CW'(1);
`endif

    assign cur_moves = (state == S_PLACE) || (state == S_FIRE);
    assign cur       = board[cursor_row][cursor_col];
    assign phase     = state;
    assign game_over = (state == S_OVER);
    assign rd_cell   = (rd_row <= ROW_MAX && rd_col <= COL_MAX) ? board[rd_row][rd_col] : CELL_EMPTY;

    // next phase, counters, error flag and cell write; actions use the pre-move cursor
    always_comb begin
        state_n  = state;
        target_n = target;
        placed_n = ships_placed;
        hits_n   = hits;
        err_n    = placement_error;
        wr_en    = 1'b0;
        wr_val   = CELL_SHIP;
        row_n    = !cur_moves ? cursor_row : (up_e & ~down_e) ? row_dec : (down_e & ~up_e) ? row_inc : cursor_row;
        col_n    = !cur_moves ? cursor_col : (left_e & ~right_e) ? col_dec : (right_e & ~left_e) ? col_inc : cursor_col;
        case (state)
            S_AMOUNT: if (amt_e) begin
                if (player_ships_input != '0 && player_ships_input <= SHIP_MAX) begin
                    target_n = player_ships_input;
                    err_n    = 1'b0;
                    state_n  = S_PLACE;
                end else begin
                    err_n = 1'b1;
                end
            end
            S_PLACE: if (place_e) begin
                if (cur == CELL_EMPTY) begin
                    wr_en    = 1'b1;
                    wr_val   = CELL_SHIP;
                    placed_n = ships_placed + CNT_W'(1);
                    err_n    = 1'b0;
                    state_n  = (placed_n == target) ? S_FIRE : S_PLACE;
                end else begin
                    err_n = 1'b1;
                end
            end
            S_FIRE: if (fire_e) begin
                if (cur == CELL_SHIP) begin
                    wr_en   = 1'b1;
                    wr_val  = CELL_HIT;
                    hits_n  = hits + CNT_W'(1);
                    err_n   = 1'b0;
                    state_n = (hits_n == target) ? S_OVER : S_FIRE;
                end else if (cur == CELL_EMPTY) begin
                    wr_en  = 1'b1;
                    wr_val = CELL_MISS;
                    err_n  = 1'b0;
                end else begin
                    err_n = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // register phase, cursor, counters and board; reset clears the whole board
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= S_AMOUNT;
            cursor_row      <= '0;
            cursor_col      <= '0;
            target          <= '0;
            ships_placed    <= '0;
            hits            <= '0;
            placement_error <= 1'b0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    board[r][c] <= CELL_EMPTY;
        end else begin
            state           <= state_n;
            cursor_row      <= row_n;
            cursor_col      <= col_n;
            target          <= target_n;
            ships_placed    <= placed_n;
            hits            <= hits_n;
            placement_error <= err_n;
            if (wr_en) board[cursor_row][cursor_col] <= wr_val;
        end
    end

endmodule

// File: tb/tb_battleship_board_ctrl.sv
// tb_battleship_board_ctrl: directed stimulus with a game-rule model checked every cycle
`timescale 1ns/100ps
module tb_battleship_board_ctrl;

    localparam int ROWS = 5;
    localparam int COLS = 5;
    localparam int MAXS = 5;

    localparam logic [6:0] UP  = 7'b1000000;
    localparam logic [6:0] DN  = 7'b0100000;
    localparam logic [6:0] LF  = 7'b0010000;
    localparam logic [6:0] RT  = 7'b0001000;
    localparam logic [6:0] AMT = 7'b0000100;
    localparam logic [6:0] PLC = 7'b0000010;
    localparam logic [6:0] FIR = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       move_up = 0, move_down = 0, move_left = 0, move_right = 0;
    logic       confirm_amount_button = 0, confirm_colocation_button = 0, fire_button = 0;
    logic [2:0] player_ships_input = '0;
    logic [2:0] rd_row = '0, rd_col = '0;
    logic [1:0] rd_cell, phase;
    logic [2:0] cursor_row, cursor_col, ships_placed, hits;
    logic       placement_error, game_over;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    int mb [ROWS][COLS];
    int mr, mc, mph, mplaced, mhits, mtarget, merr;
    bit pu, pd, pl, pr, pa, pp, pf;

    battleship_board_ctrl dut (
        .clk                       (clk),
        .rst                       (rst),
        .move_up                   (move_up),
        .move_down                 (move_down),
        .move_left                 (move_left),
        .move_right                (move_right),
        .player_ships_input        (player_ships_input),
        .confirm_amount_button     (confirm_amount_button),
        .confirm_colocation_button (confirm_colocation_button),
        .fire_button               (fire_button),
        .rd_row                    (rd_row),
        .rd_col                    (rd_col),
        .rd_cell                   (rd_cell),
        .cursor_row                (cursor_row),
        .cursor_col                (cursor_col),
        .ships_placed              (ships_placed),
        .hits                      (hits),
        .phase                     (phase),
        .placement_error           (placement_error),
        .game_over                 (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // game rules applied once per clock edge from the button levels
    task automatic model_step();
        bit eu, ed, el, er, ea, ep, ef;
        int ph0, r0, c0;
        if (!rst) begin
            foreach (mb[r, c]) mb[r][c] = 0;
            mr = 0; mc = 0; mph = 0; mplaced = 0; mhits = 0; mtarget = 0; merr = 0;
            {pu, pd, pl, pr, pa, pp, pf} = '0;
            return;
        end
        eu = move_up & !pu;   ed = move_down & !pd;  el = move_left & !pl; er = move_right & !pr;
        ea = confirm_amount_button & !pa; ep = confirm_colocation_button & !pp; ef = fire_button & !pf;
        {pu, pd, pl, pr, pa, pp, pf} = {move_up, move_down, move_left, move_right,
                                        confirm_amount_button, confirm_colocation_button, fire_button};
        ph0 = mph; r0 = mr; c0 = mc;
        if (ph0 == 0 && ea) begin
            if (player_ships_input >= 1 && player_ships_input <= MAXS) begin
                mtarget = player_ships_input; merr = 0; mph = 1;
            end else merr = 1;
        end
        if (ph0 == 1 && ep) begin
            if (mb[r0][c0] == 0) begin
                mb[r0][c0] = 1; mplaced++; merr = 0;
                if (mplaced == mtarget) mph = 2;
            end else merr = 1;
        end
        if (ph0 == 2 && ef) begin
            if (mb[r0][c0] == 1) begin
                mb[r0][c0] = 3; mhits++; merr = 0;
                if (mhits == mtarget) mph = 3;
            end else if (mb[r0][c0] == 0) begin
                mb[r0][c0] = 2; merr = 0;
            end else merr = 1;
        end
        if (ph0 == 1 || ph0 == 2) begin
`ifdef CURSOR_WRAP_EN
            if (eu && !ed) mr = (mr + ROWS - 1) % ROWS;
            if (ed && !eu) mr = (mr + 1) % ROWS;
            if (el && !er) mc = (mc + COLS - 1) % COLS;
            if (er && !el) mc = (mc + 1) % COLS;
`else
            if (eu && !ed) mr = (mr > 0) ? mr - 1 : 0;
            if (ed && !eu) mr = (mr < ROWS - 1) ? mr + 1 : mr;
            if (el && !er) mc = (mc > 0) ? mc - 1 : 0;
            if (er && !el) mc = (mc < COLS - 1) ? mc + 1 : mc;
`endif
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // compare every output and the whole board against the model between edges
    initial forever begin
        logic [1:0] bg;
        int be, br, bc;
        bit bad;
        @(negedge clk);
        if (chk_en) begin
            chk("phase", phase, mph);
            chk("cursor_row", cursor_row, mr);
            chk("cursor_col", cursor_col, mc);
            chk("ships_placed", ships_placed, mplaced);
            chk("hits", hits, mhits);
            chk("placement_error", placement_error, merr);
            chk("game_over", game_over, mph == 3);
            bad = 0; br = 0; bc = 0; bg = '0; be = 0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    rd_row = 3'(r);
                    rd_col = 3'(c);
                    #0.1;
                    if ((r == 0 && c == 0) || (!bad && rd_cell !== 2'(mb[r][c]))) begin
                        bg = rd_cell; be = mb[r][c]; br = r; bc = c;
                        bad = (rd_cell !== 2'(mb[r][c]));
                    end
                end
            chk($sformatf("cell(%0d,%0d)", br, bc), bg, be);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [6:0] b);
        {move_up, move_down, move_left, move_right,
         confirm_amount_button, confirm_colocation_button, fire_button} = b;
        tick();
        {move_up, move_down, move_left, move_right,
         confirm_amount_button, confirm_colocation_button, fire_button} = '0;
        tick();
    endtask

    initial begin
        int up_row;
`ifdef CURSOR_WRAP_EN
        up_row = 4;
`else
        up_row = 0;
`endif
        rst = 0;
        tick(); tick();
        chk_en = 1;
        chk("rst_phase", phase, 0);
        chk("rst_row", cursor_row, 0);
        chk("rst_col", cursor_col, 0);
        chk("rst_err", placement_error, 0);
        rst = 1;
        tick();

        player_ships_input = 3'd0; press(AMT);
        chk("amt0_err", placement_error, 1);
        chk("amt0_phase", phase, 0);
        player_ships_input = 3'd6; press(AMT);
        chk("amt6_err", placement_error, 1);
        player_ships_input = 3'd3; press(AMT);
        chk("amt3_phase", phase, 1);
        chk("amt3_err", placement_error, 0);

        press(RT); press(DN);
        chk("move_row", cursor_row, 1);
        chk("move_col", cursor_col, 1);
        press(PLC);
        chk("place1_cnt", ships_placed, 1);
        chk("model_cell11_ship", mb[1][1], 1);
        press(PLC);
        chk("replace_err", placement_error, 1);
        chk("replace_cnt", ships_placed, 1);

        press(UP | LF);
        chk("diag_row", cursor_row, 0);
        chk("diag_col", cursor_col, 0);
        press(PLC);
        chk("place2_cnt", ships_placed, 2);
        chk("place2_err", placement_error, 0);
        press(UP);
        chk("edge_up_row", cursor_row, up_row);
        press(UP | DN);
        chk("cancel_row", cursor_row, up_row);
        for (int i = 0; i < 6 && cursor_row != 3'd4; i++) press(DN);
        move_right = 1;
        repeat (10) tick();
        move_right = 0;
        tick();
        chk("hold_col", cursor_col, 1);
        repeat (3) press(RT);
        chk("col4", cursor_col, 4);
        press(PLC);
        chk("place3_phase", phase, 2);
        chk("place3_cnt", ships_placed, 3);

        press(UP | LF); press(UP | LF);
        chk("fire_row", cursor_row, 2);
        press(FIR);
        chk("model_cell22_miss", mb[2][2], 2);
        chk("miss_err", placement_error, 0);
        chk("miss_hits", hits, 0);
        press(FIR);
        chk("refire_err", placement_error, 1);
        press(UP | LF); press(FIR);
        chk("hit1", hits, 1);
        chk("hit1_err", placement_error, 0);
        press(UP | LF | FIR);
        chk("premove_fire_err", placement_error, 1);
        chk("premove_row", cursor_row, 0);
        chk("premove_hits", hits, 1);
        press(FIR);
        chk("hit2", hits, 2);
        repeat (4) press(DN | RT);
        press(FIR);
        chk("hit3", hits, 3);
        chk("over_flag", game_over, 1);
        chk("over_phase", phase, 3);
        press(LF); press(PLC); press(FIR); press(AMT);
        chk("over_col", cursor_col, 4);
        chk("over_phase_hold", phase, 3);
        chk("model_cell44_hit", mb[4][4], 3);

        rst = 0; tick(); rst = 1; tick();
        player_ships_input = 3'd2; press(AMT);
        press(PLC); press(RT); press(PLC);
        chk("game2_phase", phase, 2);
        press(FIR);
        chk("game2_hits", hits, 1);
        press(DN | RT);
        rst = 0;
        tick();
        chk("midrst_row", cursor_row, 0);
        chk("midrst_col", cursor_col, 0);
        chk("midrst_phase", phase, 0);
        chk("midrst_hits", hits, 0);
        chk("model_midrst_cell01", mb[0][1], 0);
        rst = 1;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
